// File: rtl/sv_clock_divider_pkg.sv
// Shared definitions for the multi-channel programmable clock divider:
// minimum legal divisor, high-phase length helper and the status code
// reported by the elaboration-time check on the reset divisor.
package sv_clock_divider_pkg;

   localparam int MIN_DIV = 1;

   typedef enum logic [1:0] {
      CFG_OK          = 2'd0,
      CFG_BAD_DEFAULT = 2'd1
   } cfg_code_e;

   // Number of high cycles in a period of d cycles: ceil(d/2)
   function automatic int half_period(input int d);
      return d - (d >> 1);
   endfunction

   // Validates the reset divisor against the counter width
   function automatic cfg_code_e check_default_div(input int def_div, input int div_w);
      if (def_div < MIN_DIV || def_div > (1 << div_w) - 1) begin
         return CFG_BAD_DEFAULT;
      end
      return CFG_OK;
   endfunction

endpackage

// File: rtl/sv_clock_divider_ch.sv
// One divider channel: period counter, pending-divisor register and the
// registered clk_out / tick / load_ack / cfg_err outputs. A new divisor is
// only adopted when the period restarts (natural wrap or sync), so every
// period runs entirely with a single divisor.
module sv_clock_divider_ch
   import sv_clock_divider_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_value,
   input  logic             div_load,
   input  logic             sync_in,
   output logic             clk_out,
   output logic             tick,
   output logic             load_pending,
   output logic             load_ack,
   output logic             cfg_err
);

   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
   localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] RESET_CNT = DIV_W'(DEFAULT_DIV - 1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] active_div;
   logic [DIV_W-1:0] pending_div;
   logic             pending;

   logic [DIV_W-1:0] cnt_next;
   logic [DIV_W-1:0] div_next;
   logic [DIV_W-1:0] half_next;
   logic             at_wrap;
   logic             restart;
   logic             apply;
   logic             load_ok;

   // Next counter/divisor: a restart (wrap or sync) zeroes the counter and adopts any pending divisor
   always_comb begin
      at_wrap   = (cnt == active_div - ONE);
      restart   = enable & (sync_in | at_wrap);
      apply     = restart & pending;
      load_ok   = div_load & (div_value != '0);
      div_next  = apply ? pending_div : active_div;
      if (restart) begin
         cnt_next = '0;
      end else if (enable) begin
         cnt_next = cnt + ONE;
      end else begin
         cnt_next = cnt;
      end
      half_next = DIV_W'(half_period(int'(div_next)));
   end

   // Channel state and registered outputs; a disabled channel freezes its counter and clock level
   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt         <= RESET_CNT;
         active_div  <= RESET_DIV;
         pending_div <= RESET_DIV;
         pending     <= 1'b0;
         clk_out     <= 1'b0;
         tick        <= 1'b0;
         load_ack    <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         active_div <= div_next;
         if (load_ok) begin
            pending_div <= div_value;
            pending     <= 1'b1;
         end else if (apply) begin
            pending     <= 1'b0;
         end
         cfg_err  <= div_load & (div_value == '0);
         load_ack <= apply;
         tick     <= restart;
         if (enable) begin
            clk_out <= (cnt_next < half_next);
         end
      end
   end

   assign load_pending = pending;

endmodule

// File: rtl/sv_clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider. Each channel divides
// clk_in by its own divisor; reset and sync_in are shared so that all
// channels can be restarted in phase.
module sv_clock_divider_multi
   import sv_clock_divider_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       enable,
   input  logic [NUM_CH*DIV_W-1:0] div_value,
   input  logic [NUM_CH-1:0]       div_load,
   input  logic                    sync_in,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       load_pending,
   output logic [NUM_CH-1:0]       load_ack,
   output logic [NUM_CH-1:0]       cfg_err
);

   localparam cfg_code_e CFG_STATUS = check_default_div(DEFAULT_DIV, DIV_W);

   // Refuse to elaborate with a reset divisor the counter cannot represent
   if (CFG_STATUS != CFG_OK) begin : g_bad_cfg
      $error("sv_clock_divider_multi: DEFAULT_DIV outside 1..2^DIV_W-1");
   end

   // One independent divider per channel, each fed its own divisor slice
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sv_clock_divider_ch #(
         .DIV_W      (DIV_W),
         .DEFAULT_DIV(DEFAULT_DIV)
      ) u_ch (
         .clk_in      (clk_in),
         .reset       (reset),
         .enable      (enable[i]),
         .div_value   (div_value[i*DIV_W +: DIV_W]),
         .div_load    (div_load[i]),
         .sync_in     (sync_in),
         .clk_out     (clk_out[i]),
         .tick        (tick[i]),
         .load_pending(load_pending[i]),
         .load_ack    (load_ack[i]),
         .cfg_err     (cfg_err[i])
      );
   end

endmodule

// File: tb/tb_sv_clock_divider_multi.sv
// Self-checking bench for sv_clock_divider_multi. Inputs are driven on the
// falling edge; the expected outputs for the following rising edge are
// pushed into a scoreboard queue at that moment and popped/compared on the
// next falling edge. Expectations come either from a hand-written vector
// table or from a small cycle model of the divider behaviour.
module tb_sv_clock_divider_multi;

   localparam int NCH     = 4;
   localparam int DW      = 8;
   localparam int DEF_DIV = 4;

   typedef struct packed {
      logic [NCH-1:0] clk;
      logic [NCH-1:0] tick;
      logic [NCH-1:0] pend;
      logic [NCH-1:0] ack;
      logic [NCH-1:0] err;
   } exp_t;

   typedef struct packed {
      logic              rst;
      logic [NCH-1:0]    en;
      logic [NCH-1:0]    ld;
      logic [NCH*DW-1:0] val;
      logic              sync;
      exp_t              exp;
   } vec_t;

   logic                 clk_in = 1'b0;
   logic                 reset = 1'b1;
   logic [NCH-1:0]       enable = '0;
   logic [NCH*DW-1:0]    div_value = '0;
   logic [NCH-1:0]       div_load = '0;
   logic                 sync_in = 1'b0;
   logic [NCH-1:0]       clk_out;
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       load_pending;
   logic [NCH-1:0]       load_ack;
   logic [NCH-1:0]       cfg_err;

   int   checks = 0;
   int   passed = 0;
   int   cycle_no = 0;
   exp_t sb[$];
   vec_t vecs[$];

   int   m_phase[NCH];
   int   m_div[NCH];
   int   m_pdiv[NCH];
   bit   m_pend[NCH];
   exp_t m_out;

   sv_clock_divider_multi #(
      .NUM_CH     (NCH),
      .DIV_W      (DW),
      .DEFAULT_DIV(DEF_DIV)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable      (enable),
      .div_value   (div_value),
      .div_load    (div_load),
      .sync_in     (sync_in),
      .clk_out     (clk_out),
      .tick        (tick),
      .load_pending(load_pending),
      .load_ack    (load_ack),
      .cfg_err     (cfg_err)
   );

   // Free-running 10-time-unit clock
   always #5 clk_in = ~clk_in;

   // Builds one table record from inputs and hand-derived expected outputs
   function automatic vec_t mkVec(input logic r, input logic [NCH-1:0] en, input logic [NCH-1:0] ld,
                                  input logic [NCH*DW-1:0] val, input logic s,
                                  input logic [NCH-1:0] c, input logic [NCH-1:0] t,
                                  input logic [NCH-1:0] p, input logic [NCH-1:0] a,
                                  input logic [NCH-1:0] e);
      vec_t v;
      v.rst      = r;
      v.en       = en;
      v.ld       = ld;
      v.val      = val;
      v.sync     = s;
      v.exp.clk  = c;
      v.exp.tick = t;
      v.exp.pend = p;
      v.exp.ack  = a;
      v.exp.err  = e;
      return v;
   endfunction

   // Reference model: tracks each channel by its phase within the period and
   // derives the clock level as phase < (div+1)/2
   task automatic modelStep(input logic r, input logic [NCH-1:0] en, input logic s,
                            input logic [NCH-1:0] ld, input logic [NCH*DW-1:0] val);
      for (int i = 0; i < NCH; i++) begin
         int v;
         bit boundary;
         v = int'(val[i*DW +: DW]);
         if (r) begin
            m_phase[i]     = DEF_DIV - 1;
            m_div[i]       = DEF_DIV;
            m_pdiv[i]      = DEF_DIV;
            m_pend[i]      = 1'b0;
            m_out.clk[i]   = 1'b0;
            m_out.tick[i]  = 1'b0;
            m_out.ack[i]   = 1'b0;
            m_out.err[i]   = 1'b0;
         end else begin
            m_out.err[i]  = ld[i] && (v == 0);
            m_out.ack[i]  = 1'b0;
            m_out.tick[i] = 1'b0;
            if (en[i]) begin
               boundary = s || (m_phase[i] == m_div[i] - 1);
               if (boundary) begin
                  if (m_pend[i]) begin
                     m_div[i]     = m_pdiv[i];
                     m_out.ack[i] = 1'b1;
                     m_pend[i]    = 1'b0;
                  end
                  m_phase[i] = 0;
               end else begin
                  m_phase[i]++;
               end
               m_out.tick[i] = (m_phase[i] == 0);
               m_out.clk[i]  = (m_phase[i] < (m_div[i] + 1) / 2);
            end
            if (ld[i] && v != 0) begin
               m_pend[i] = 1'b1;
               m_pdiv[i] = v;
            end
         end
         m_out.pend[i] = m_pend[i];
      end
   endtask

   // Single comparison with pass/fail bookkeeping
   task automatic compare(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
      checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cycle_no, act, exp);
      end else begin
         passed++;
      end
   endtask

   // Pops the expectation for the most recent rising edge and checks all outputs
   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      compare("clk_out", clk_out, e.clk);
      compare("tick", tick, e.tick);
      compare("load_pending", load_pending, e.pend);
      compare("load_ack", load_ack, e.ack);
      compare("cfg_err", cfg_err, e.err);
   endtask

   // Checks the previous edge, drives the next inputs and queues their expected result
   task automatic applyStimulus(input logic r, input logic [NCH-1:0] en, input logic s,
                                input logic [NCH-1:0] ld, input logic [NCH*DW-1:0] val,
                                input logic use_hand, input exp_t hand);
      @(negedge clk_in);
      checkOutput();
      cycle_no++;
      reset     = r;
      enable    = en;
      sync_in   = s;
      div_load  = ld;
      div_value = val;
      modelStep(r, en, s, ld, val);
      if (use_hand) sb.push_back(hand);
      else          sb.push_back(m_out);
   endtask

   // Model-checked cycle with reset released
   task automatic step(input logic [NCH-1:0] en, input logic s, input logic [NCH-1:0] ld,
                       input logic [NCH*DW-1:0] val);
      applyStimulus(1'b0, en, s, ld, val, 1'b0, '0);
   endtask

   // Runs n idle cycles with the given enables
   task automatic idle(input int n, input logic [NCH-1:0] en);
      for (int k = 0; k < n; k++) step(en, 1'b0, '0, '0);
   endtask

   // Test sequence: hand table first, then model-checked corner cases and a random soak
   initial begin
      bit found;
      modelStep(1'b1, '0, 1'b0, '0, '0);

      // Reset, DEFAULT_DIV=4 pattern 1100, then ch0 loads 5 when its count is 1
      for (int k = 0; k < 3; k++) vecs.push_back(mkVec(1, 4'h0, 4'h0, '0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h1, 32'h0000_0005, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hE, 4'hE, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mkVec(0, 4'hF, 4'h0, '0, 0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0));
      foreach (vecs[k]) applyStimulus(vecs[k].rst, vecs[k].en, vecs[k].sync, vecs[k].ld, vecs[k].val, 1'b1, vecs[k].exp);
      idle(8, 4'hF);

      // Ch2 rejected zero divisor, then divisor 1 gives a constant-high clock
      step(4'hF, 1'b0, 4'h4, 32'h0000_0000);
      idle(6, 4'hF);
      step(4'hF, 1'b0, 4'h4, 32'h0001_0000);
      idle(10, 4'hF);

      // Ch1 frozen for 7 cycles during its first high cycle
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         step(4'hF, 1'b0, '0, '0);
         if (m_phase[1] == 0) found = 1'b1;
      end
      if (!found) begin
         checks++;
         $display("[TB] FAIL ch1_phase_search cycle %0d: got no period start expected one within 12 cycles", cycle_no);
      end
      idle(7, 4'hD);
      idle(8, 4'hF);

      // Divisors 3/4/6/7, then sync aligns all channels
      step(4'hF, 1'b0, 4'hF, {8'd7, 8'd6, 8'd4, 8'd3});
      idle(3, 4'hF);
      step(4'hF, 1'b1, '0, '0);
      idle(30, 4'hF);

      // Ch3 load discarded by reset, then a load coincident with sync
      step(4'hF, 1'b0, 4'h8, {8'd9, 24'd0});
      applyStimulus(1'b1, 4'hF, 1'b0, '0, '0, 1'b0, '0);
      applyStimulus(1'b1, 4'hF, 1'b0, '0, '0, 1'b0, '0);
      idle(10, 4'hF);
      step(4'hF, 1'b1, 4'h1, 32'h0000_0002);
      idle(10, 4'hF);

      // Random soak: mostly-enabled channels, sporadic loads (including zero) and syncs
      for (int k = 0; k < 200; k++) begin
         logic [NCH-1:0]    en;
         logic [NCH-1:0]    ld;
         logic [NCH*DW-1:0] val;
         for (int c = 0; c < NCH; c++) begin
            en[c]            = ($urandom_range(0, 7) != 0);
            ld[c]            = ($urandom_range(0, 9) == 0);
            val[c*DW +: DW]  = DW'($urandom_range(0, 9));
         end
         step(en, ($urandom_range(0, 24) == 0), ld, val);
      end

      @(negedge clk_in);
      checkOutput();
      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
